// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control path: opcodes, IR field positions,
// fetch FSM state encoding and the branch-condition helper.
package sisc_pkg;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam int IR_OP_MSB  = 31;
  localparam int IR_OP_LSB  = 28;
  localparam int IR_MM_MSB  = 27;
  localparam int IR_MM_LSB  = 24;
  localparam int IR_IMM_MSB = 15;
  localparam int IR_IMM_LSB = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  // A branch condition holds when any status flag selected by the mask is set.
  function automatic logic branch_cond(input logic [3:0] mask, input logic [3:0] flags);
    return |(mask & flags);
  endfunction

endpackage

// File: rtl/sisc_br_unit.sv
// Combinational branch resolver: taken decision and target address from the
// current IR fields, status flags and (already advanced) PC.
module sisc_br_unit
  import sisc_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [3:0]    opcode,
  input  logic [3:0]    mm,
  input  logic [3:0]    stat,
  input  logic [AW-1:0] pc,
  input  logic [15:0]   imm,
  output logic          taken,
  output logic [AW-1:0] target
);

  logic          cond_s;
  logic [AW-1:0] imm_zext_s;
  logic [AW-1:0] imm_sext_s;

  // Decode the branch type and select the matching target.
  always_comb begin
    cond_s     = branch_cond(mm, stat);
    imm_zext_s = AW'(imm);
    imm_sext_s = AW'($signed(imm));
    taken      = 1'b0;
    target     = pc;
    case (opcode)
      OP_BRA: begin
        taken  = cond_s;
        target = imm_zext_s;
      end
      OP_BRR: begin
        taken  = cond_s;
        target = pc + imm_sext_s;
      end
      OP_BNE: begin
        taken  = !cond_s;
        target = imm_zext_s;
      end
      default: begin
        taken  = 1'b0;
        target = pc;
      end
    endcase
  end

endmodule

// File: rtl/sisc_fetch.sv
// Instruction-supply side of the SISC control path: PC, IR and status
// register, req/ack instruction fetch and branch application.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          ir_load,
  input  logic          pc_write,
  input  logic          stat_en,
  input  logic [3:0]    stat_in,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] instr,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    stat,
  output logic [AW-1:0] pc,
  output logic          br_taken,
  output logic          busy,
  output logic          err
);

  fetch_state_e  state_r;
  logic [AW-1:0] pc_r;
  logic [DW-1:0] ir_r;
  logic [3:0]    stat_r;
  logic [AW-1:0] br_target_s;
  logic [AW-1:0] fetch_pc_s;

  assign instr  = ir_r;
  assign opcode = ir_r[IR_OP_MSB:IR_OP_LSB];
  assign mm     = ir_r[IR_MM_MSB:IR_MM_LSB];
  assign stat   = stat_r;
  assign pc     = pc_r;

  sisc_br_unit #(.AW(AW)) u_br (
    .opcode (ir_r[IR_OP_MSB:IR_OP_LSB]),
    .mm     (ir_r[IR_MM_MSB:IR_MM_LSB]),
    .stat   (stat_r),
    .pc     (pc_r),
    .imm    (ir_r[IR_IMM_MSB:IR_IMM_LSB]),
    .taken  (br_taken),
    .target (br_target_s)
  );

  // A same-cycle branch redirects the fetch, so the request uses the updated PC.
  always_comb begin
    if (pc_write && br_taken) begin
      fetch_pc_s = br_target_s;
    end else begin
      fetch_pc_s = pc_r;
    end
  end

  // Fetch FSM plus PC, IR, status and error registers.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_PC;
      ir_r      <= '0;
      stat_r    <= 4'd0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (stat_en) begin
        stat_r <= stat_in;
      end
      case (state_r)
        ST_IDLE: begin
          pc_r <= fetch_pc_s;
          if (ir_load) begin
            imem_addr <= fetch_pc_s;
            imem_req  <= 1'b1;
            busy      <= 1'b1;
            state_r   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ir_load || pc_write) begin
            err <= 1'b1;
          end
          if (imem_ack) begin
            ir_r     <= imem_rdata;
            pc_r     <= pc_r + AW'(1);
            imem_req <= 1'b0;
            busy     <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// Directed bench for sisc_fetch: fetch results are checked by a scoreboard
// monitor on busy falling; branch, error and reset behaviour checked inline.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        ir_load, pc_write, stat_en;
  logic [3:0]  stat_in;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [3:0]  opcode, mm, stat;
  logic [15:0] pc;
  logic        br_taken, busy, err;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  sisc_fetch dut (
    .clk(clk), .rst_f(rst_f), .ir_load(ir_load), .pc_write(pc_write),
    .stat_en(stat_en), .stat_in(stat_in), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .mm(mm), .stat(stat), .pc(pc),
    .br_taken(br_taken), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stat(input logic [3:0] v);
    stat_en = 1'b1;
    stat_in = v;
    step();
    stat_en = 1'b0;
  endtask

  task automatic do_pcw();
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
  endtask

  // Fetch from addr, acking in the delay-th request cycle; optionally with a
  // coincident pc_write, optionally injecting ir_load/pc_write while busy.
  task automatic fetch(input logic [15:0] addr, input logic [31:0] rdata,
                       input int delay, input bit pcw, input bit inject);
    exp_q.push_back({rdata, addr + 16'd1});
    ir_load  = 1'b1;
    pc_write = pcw;
    step();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    for (int c = 1; c <= delay; c++) begin
      check("req_high", 32'(imem_req), 32'd1);
      check("req_addr", 32'(imem_addr), 32'(addr));
      check("pc_hold", 32'(pc), 32'(addr));
      check("busy_high", 32'(busy), 32'd1);
      if (inject && c == 2) ir_load = 1'b1;
      if (inject && c == 3) pc_write = 1'b1;
      if (c == delay) begin
        imem_ack   = 1'b1;
        imem_rdata = rdata;
      end
      step();
      ir_load  = 1'b0;
      pc_write = 1'b0;
      imem_ack = 1'b0;
    end
    check("req_low", 32'(imem_req), 32'd0);
  endtask

  // Scoreboard monitor: a completed fetch is seen as busy falling.
  initial begin : monitor
    logic        prev_busy;
    logic [47:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_f) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: fetch completed with no expectation, instr 0x%0h", instr);
          end else begin
            e = exp_q.pop_front();
            check("sb_instr", instr, e[47:16]);
            check("sb_pc", 32'(pc), 32'(e[15:0]));
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_f = 1'b0; ir_load = 1'b0; pc_write = 1'b0; stat_en = 1'b0;
    stat_in = 4'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
    step(); step();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_stat", 32'(stat), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_br", 32'(br_taken), 32'd0);
    rst_f = 1'b1;
    step();

    // Basic fetch, ack in third request cycle.
    fetch(16'h0000, 32'h10000005, 3, 1'b0, 1'b0);
    step();
    check("ld_opcode", 32'(opcode), 32'd1);
    check("ld_pc", 32'(pc), 32'd1);
    check("ld_busy", 32'(busy), 32'd0);

    // BRA taken / not taken.
    set_stat(4'h1);
    check("stat_load", 32'(stat), 32'h1);
    fetch(16'h0001, 32'h41000020, 1, 1'b0, 1'b0);
    check("bra_mm", 32'(mm), 32'd1);
    check("bra_taken", 32'(br_taken), 32'd1);
    do_pcw();
    check("bra_pc", 32'(pc), 32'h0020);
    set_stat(4'h2);
    fetch(16'h0020, 32'h41000020, 1, 1'b0, 1'b0);
    check("bra_nt", 32'(br_taken), 32'd0);
    do_pcw();
    check("bra_nt_pc", 32'(pc), 32'h0021);

    // BRR backward and wrap.
    set_stat(4'h1);
    fetch(16'h0021, 32'h41000010, 1, 1'b0, 1'b0);
    do_pcw();
    check("bra_10", 32'(pc), 32'h0010);
    fetch(16'h0010, 32'h5100FFFE, 2, 1'b0, 1'b0);
    check("brr_pc_adv", 32'(pc), 32'h0011);
    check("brr_taken", 32'(br_taken), 32'd1);
    do_pcw();
    check("brr_pc", 32'(pc), 32'h000F);
    fetch(16'h000F, 32'h4100FFFF, 1, 1'b0, 1'b0);
    do_pcw();
    check("bra_ffff", 32'(pc), 32'hFFFF);
    fetch(16'hFFFF, 32'h5100FFFF, 1, 1'b0, 1'b0);
    check("pc_inc_wrap", 32'(pc), 32'h0000);
    do_pcw();
    check("brr_wrap", 32'(pc), 32'hFFFF);

    // BNE taken / not taken.
    set_stat(4'h0);
    fetch(16'hFFFF, 32'h61000030, 1, 1'b0, 1'b0);
    check("bne_taken", 32'(br_taken), 32'd1);
    do_pcw();
    check("bne_pc", 32'(pc), 32'h0030);
    set_stat(4'h1);
    fetch(16'h0030, 32'h61000030, 1, 1'b0, 1'b0);
    check("bne_nt", 32'(br_taken), 32'd0);
    do_pcw();
    check("bne_nt_pc", 32'(pc), 32'h0031);

    // stat_en with pc_write: decision uses old stat (1 -> not taken).
    stat_en = 1'b1; stat_in = 4'h0; pc_write = 1'b1;
    step();
    stat_en = 1'b0; pc_write = 1'b0;
    check("old_stat_pc", 32'(pc), 32'h0031);
    check("new_stat", 32'(stat), 32'h0);

    // pc_write and ir_load together: fetch goes to the branch target.
    fetch(16'h0030, 32'h61000040, 1, 1'b1, 1'b0);
    check("co_pc", 32'(pc), 32'h0031);
    check("co_taken", 32'(br_taken), 32'd1);
    check("err_clean", 32'(err), 32'd0);

    // Strobes while busy are ignored and flagged.
    fetch(16'h0031, 32'h80000000, 4, 1'b0, 1'b1);
    check("viol_pc", 32'(pc), 32'h0032);
    check("viol_err", 32'(err), 32'd1);
    step();
    check("viol_no_refetch", 32'(imem_req), 32'd0);
    check("viol_opcode", 32'(opcode), 32'd8);

    // Reset mid-request, then a late ack.
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    check("pre_rst_req", 32'(imem_req), 32'd1);
    step();
    rst_f = 1'b0;
    #1;
    check("rst_req_drop", 32'(imem_req), 32'd0);
    check("rst_mid_pc", 32'(pc), 32'd0);
    check("rst_mid_instr", instr, 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    step();
    rst_f = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack = 1'b0;
    step();
    check("late_ack_instr", instr, 32'd0);
    check("late_ack_pc", 32'(pc), 32'd0);
    check("late_ack_req", 32'(imem_req), 32'd0);
    check("late_ack_busy", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Instruction-supply side of the SISC control path. Holds the PC, instruction register (IR) and status register.
- Fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Resolves BRA/BRR/BNE branches.
- Produces the opcode, mm and stat fields consumed by the control FSM, and takes that FSM's ir_load, pc_write and stat_en strobes.

Parameters:
- AW, 16, instruction address / PC width
- DW, 32, instruction word width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock
- rst_f  in  1  asynchronous active-low reset
- ir_load  in  1  1-cycle strobe from ctrl: fetch instruction at PC into IR
- pc_write  in  1  1-cycle strobe from ctrl: apply branch decision to PC
- stat_en  in  1  load stat register from stat_in
- stat_in  in  4  ALU status flags (C,N,V,Z)
- imem_req  out  1  instruction memory request
- imem_addr  out  AW  request address
- imem_ack  in  1  memory data valid
- imem_rdata  in  DW  instruction word
- instr  out  DW  IR contents
- opcode  out  4  IR[31:28]
- mm  out  4  IR[27:24]
- stat  out  4  status register
- pc  out  AW  current PC
- br_taken  out  1  combinational branch-taken decision for the current IR
- busy  out  1  fetch in progress
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_f low, async): pc=RESET_PC, IR=0 (opcode NOOP), stat=0, imem_req=0, busy=0, err=0, state IDLE.
  - Reset during a request drops imem_req immediately. A late imem_ack after reset is ignored.
- FSM IDLE:
  - ir_load: register imem_addr=pc, assert imem_req and busy next cycle -> REQ.
- FSM REQ:
  - imem_req held high and imem_addr held stable until imem_ack is sampled high.
  - On ack: IR<=imem_rdata, pc<=pc+1 (mod 2^AW), imem_req<=0, busy<=0 -> IDLE.
  - Minimum latency ir_load to IR valid: 2 cycles (ack in first REQ cycle).
  - No timeout; waits indefinitely.
- imem_ack while not in REQ: ignored.
- ir_load while busy: ignored; err<=1.
- Branch decision, combinational on IR and stat, with cond = |(mm & stat):
  - BRA(4): taken = cond; target = IR[15:0].
  - BRR(5): taken = cond; target = pc + sign-extend(IR[15:0]), wrap mod 2^AW. pc has already advanced past the branch.
  - BNE(6): taken = !cond; target = IR[15:0].
  - All other opcodes: br_taken=0.
- pc_write in IDLE with br_taken=1: pc<=target next edge. With br_taken=0: pc unchanged.
- pc_write while busy: ignored; err<=1.
- pc_write and ir_load in the same IDLE cycle: the PC update takes effect first, so the fetch uses the new target address. The request address equals the updated pc.
- stat_en: stat<=stat_in on the next edge, independent of FSM state.
  - stat_en coincident with pc_write: the branch decision uses the old stat.
- err clears only on reset.
- opcode and mm are always direct slices of IR.

Decomposition:
- Shared package sisc_pkg: opcode constants (NOOP=0, LOD=1, STR=2, BRA=4, BRR=5, BNE=6, ALU_OP=8, HLT=15), IR field bit positions, fetch-FSM state encoding (IDLE, REQ).
- Sub-module sisc_br_unit: combinational br_taken/target from opcode, mm, stat, pc and IR[15:0]; reused by future pipelined control.

Test Plan:
- Reset then ir_load with memory acking after 3 cycles, rdata=0x10000005 -> imem_req high exactly 3 cycles at addr 0, address stable throughout; then opcode=1, pc=1, busy=0.
- stat_en with stat_in=0x1; IR=0x41000020 (BRA, mm=1); pc_write -> br_taken=1, pc=0x0020. Repeat with stat=0x2 -> pc unchanged.
- IR=0x5100FFFE (BRR, offset -2) at pc=0x0011, stat=0x1, pc_write -> pc=0x000F. Also pc=0x0000 with offset -1 -> pc=0xFFFF (wrap).
- IR=0x61000030 (BNE, mm=1), stat=0x0, pc_write -> pc=0x0030. With stat=0x1 -> pc unchanged.
- ir_load pulse during REQ, and pc_write during REQ -> neither affects pc or imem_addr, err=1, the original fetch completes normally.
- rst_f low mid-REQ, then ack arrives after reset release with no ir_load -> imem_req=0 immediately on reset, IR=0, pc=0, late ack ignored.
